// File: rtl/idct_block_loader.sv
// Serial coefficient loader for the 64-input IDCT: de-scans, zero-fills, and flags result timing.
// Build option IDCT_LOADER_ZIGZAG_EN: input arrives in JPEG zig-zag order; otherwise natural order.
module idct_block_loader #(
    parameter int DATA_W  = 16,
    parameter int LATENCY = 29
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_last,
    output logic [64*DATA_W-1:0]  blk,
    output logic                  blk_valid,
    output logic                  res_valid,
    output logic [7:0]            blk_count
);
    localparam int BW = 64 * DATA_W;

    logic [BW-1:0]      fill;
    logic [BW-1:0]      merged;
    logic [5:0]         idx;
    logic [5:0]         pos;
    logic [LATENCY-1:0] lat;
    logic               xfer;
    logic               commit;

`ifdef IDCT_LOADER_ZIGZAG_EN
    localparam logic [5:0] ZZ [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };
    assign pos = ZZ[idx];
`else
    assign pos = idx;
`endif

    assign xfer   = in_valid && in_ready;
    assign commit = in_last || (idx == 6'd63);

    // Fill buffer with the incoming word already placed; used for both commit and accumulate.
    always_comb begin
        merged = fill;
        merged[int'(pos)*DATA_W +: DATA_W] = in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready  <= 1'b0;
            blk       <= '0;
            blk_valid <= 1'b0;
            blk_count <= 8'd0;
            fill      <= '0;
            idx       <= 6'd0;
            lat       <= '0;
        end else begin
            in_ready  <= 1'b1;
            blk_valid <= 1'b0;
            lat       <= (lat << 1) | LATENCY'(blk_valid);
            if (xfer) begin
                if (commit) begin
                    blk       <= merged;
                    fill      <= '0;
                    idx       <= 6'd0;
                    blk_valid <= 1'b1;
                    blk_count <= blk_count + 8'd1;
                end else begin
                    fill <= merged;
                    idx  <= idx + 6'd1;
                end
            end
        end
    end

    // Oldest stage of the delay line marks the cycle IDCT results match a committed block.
    assign res_valid = lat[LATENCY-1];

endmodule
